// File: rtl/rr_arb_mux.sv
// N-channel valid/ready selector with round-robin or fixed-priority arbitration.
// The winning word is captured in a one-entry output register tagged with its source index.
module rr_arb_mux #(
  parameter  int WIDTH     = 32,
  parameter  int N         = 4,
  parameter  bit PRIO_MODE = 1'b0,
  localparam int SELW      = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  input  logic               out_ready
);

  // Handshake rules: a transfer happens on channel i when in_valid[i] && in_ready[i],
  // and on the output when out_valid && out_ready. in_ready is a combinational function
  // of in_valid, so producers must never make in_valid depend on in_ready.

  localparam logic [SELW:0]   N_EXT = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST  = SELW'(N - 1);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  ptr_nxt;
  logic [SELW-1:0]  gnt_idx;
  logic             gnt_found;
  logic [N-1:0]     grant;
  logic [SELW:0]    scan_sum;
  logic [SELW-1:0]  scan_idx;
  logic [WIDTH-1:0] mux_data;
  logic             can_accept;
  logic             load;
  logic             drain;

  // Output register is free when empty or being drained this cycle; reset blocks all accepts.
  assign can_accept = !out_valid || out_ready;
  assign load       = rst_n && !flush && can_accept && (|in_valid);
  assign drain      = out_valid && out_ready;

  // Search order: lowest index first in priority mode, otherwise starting at ptr and wrapping.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < N; k++) begin
      if (PRIO_MODE) begin
        scan_sum = (SELW+1)'(k);
      end else begin
        scan_sum = {1'b0, ptr} + (SELW+1)'(k);
        if (scan_sum >= N_EXT) begin
          scan_sum = scan_sum - N_EXT;
        end
      end
      scan_idx = scan_sum[SELW-1:0];
      if (!gnt_found && in_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (gnt_found) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  assign in_ready = load ? grant : '0;

  // One-hot AND-OR select keeps the data path free of index arithmetic.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        mux_data = mux_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign ptr_nxt = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_src   <= gnt_idx;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  // Pointer only moves on an accepted word; priority mode leaves it parked at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (load && !PRIO_MODE) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a round-robin and a fixed-priority instance share stimulus.
module tb_rr_arb_mux;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic           flush;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic           out_ready;

  logic [N-1:0]   rr_in_ready;
  logic           rr_out_valid;
  logic [W-1:0]   rr_out_data;
  logic [1:0]     rr_out_src;

  logic [N-1:0]   pr_in_ready;
  logic           pr_out_valid;
  logic [W-1:0]   pr_out_data;
  logic [1:0]     pr_out_src;

  int tests;
  int fails;

  rr_arb_mux #(.WIDTH(W), .N(N), .PRIO_MODE(1'b0)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (rr_in_ready),
    .out_valid (rr_out_valid),
    .out_data  (rr_out_data),
    .out_src   (rr_out_src),
    .out_ready (out_ready)
  );

  rr_arb_mux #(.WIDTH(W), .N(N), .PRIO_MODE(1'b1)) u_pr (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (pr_in_ready),
    .out_valid (pr_out_valid),
    .out_data  (pr_out_data),
    .out_src   (pr_out_src),
    .out_ready (out_ready)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_std_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'(i + 'h10);
  endtask

  task automatic check_rr_out(input string tag, input logic [1:0] src, input logic [31:0] data);
    check({tag, "_valid"}, 32'(rr_out_valid), 32'd1);
    check({tag, "_src"},   32'(rr_out_src),   32'(src));
    check({tag, "_data"},  rr_out_data,       data);
  endtask

  logic [1:0] seq_all [6];
  logic [1:0] seq_sparse [3];

  initial begin
    tests = 0;
    fails = 0;
    seq_all    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    seq_sparse = '{2'd1, 2'd3, 2'd1};

    // Reset state, with requests present to confirm in_ready stays low.
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    set_std_data();
    #12;
    check("rst_in_ready",  32'(rr_in_ready),  32'h0);
    check("rst_out_valid", 32'(rr_out_valid), 32'h0);
    check("rst_out_data",  rr_out_data,       32'h0);
    check("rst_out_src",   32'(rr_out_src),   32'h0);
    in_valid = 4'b0000;
    #2 rst_n = 1'b1;
    tick();

    // Single request on channel 2.
    in_valid = 4'b0100;
    in_data[2*W +: W] = 32'hA5A5_0002;
    #1;
    check("t1_in_ready", 32'(rr_in_ready), 32'h4);
    tick();
    check_rr_out("t1", 2'd2, 32'hA5A5_0002);
    set_std_data();

    // All valid: pointer now 3, so channel 3 wins first.
    in_valid = 4'b1111;
    #1;
    check("t1_ptr3_ready", 32'(rr_in_ready), 32'h8);
    tick();
    check_rr_out("t1_ptr3", 2'd3, 32'h13);

    // Fairness sweep; the priority instance must keep picking channel 0.
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("t2_ready%0d", c), 32'(rr_in_ready), 32'(4'b0001 << seq_all[c]));
      check($sformatf("t2_pr_ready%0d", c), 32'(pr_in_ready), 32'h1);
      tick();
      check_rr_out($sformatf("t2_out%0d", c), seq_all[c], 32'(seq_all[c]) + 32'h10);
      check($sformatf("t2_pr_src%0d", c), 32'(pr_out_src), 32'h0);
    end

    // Backpressure: holding output register (src 1) while channels 1 and 3 wait.
    out_ready = 1'b0;
    in_valid  = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("t3_ready%0d", c), 32'(rr_in_ready), 32'h0);
      tick();
      check_rr_out($sformatf("t3_hold%0d", c), 2'd1, 32'h11);
    end
    out_ready = 1'b1;
    #1;
    check("t3_release_ready", 32'(rr_in_ready), 32'h8);
    tick();
    check_rr_out("t3_release", 2'd3, 32'h13);

    // Fixed priority starves channel 3; round-robin alternates 1,3,1.
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("t4_pr_ready%0d", c), 32'(pr_in_ready), 32'h2);
      check($sformatf("t4_pr_starve%0d", c), 32'(pr_in_ready[3]), 32'h0);
      check($sformatf("t4_rr_ready%0d", c), 32'(rr_in_ready), 32'(4'b0001 << seq_sparse[c]));
      tick();
      check($sformatf("t4_pr_src%0d", c), 32'(pr_out_src), 32'h1);
      check($sformatf("t4_pr_data%0d", c), pr_out_data, 32'h11);
      check_rr_out($sformatf("t4_rr%0d", c), seq_sparse[c], 32'(seq_sparse[c]) + 32'h10);
    end

    // Flush with a full output register and channel 0 requesting; pointer is 2.
    flush     = 1'b1;
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    #1;
    check("t5_flush_ready", 32'(rr_in_ready), 32'h0);
    tick();
    check("t5_flush_valid", 32'(rr_out_valid), 32'h0);
    check("t5_flush_pr_valid", 32'(pr_out_valid), 32'h0);
    flush     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("t5_after_ready", 32'(rr_in_ready), 32'h1);
    tick();
    check_rr_out("t5_load0", 2'd0, 32'h10);

    // Pointer is 1; a flush cycle must not move it.
    flush    = 1'b1;
    in_valid = 4'b1111;
    #1;
    check("t5_flush2_ready", 32'(rr_in_ready), 32'h0);
    tick();
    check("t5_flush2_valid", 32'(rr_out_valid), 32'h0);
    flush = 1'b0;
    #1;
    check("t5_ptr_kept", 32'(rr_in_ready), 32'h2);
    tick();
    check_rr_out("t5_load1", 2'd1, 32'h11);

    // Asynchronous reset mid-cycle with a held word and pointer 2.
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid",    32'(rr_out_valid), 32'h0);
    check("t6_data",     rr_out_data,       32'h0);
    check("t6_src",      32'(rr_out_src),   32'h0);
    check("t6_in_ready", 32'(rr_in_ready),  32'h0);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("t6_first_ready", 32'(rr_in_ready), 32'h1);
    tick();
    check_rr_out("t6_first", 2'd0, 32'h10);

    // No requests: the held word drains and nothing reloads.
    in_valid = 4'b0000;
    #1;
    check("t7_idle_ready", 32'(rr_in_ready), 32'h0);
    tick();
    check("t7_drained", 32'(rr_out_valid), 32'h0);
    in_valid = 4'b1111;
    #1;
    check("t7_ptr_kept", 32'(rr_in_ready), 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
